// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32I core: one state per clock, Moore-style
// datapath selects and write enables derived from the current state and the IR fields.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [6:0]         OP,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic               Zero,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         ResultSrc,
  output logic [2:0]         ALUControl,
  output logic               AdrSrc,
  output logic               PCWrite,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               IRWrite,
  output logic               Illegal,
  output logic [STATE_W-1:0] STATE
);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_BEQ   = 7'b1100011;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECR    = STATE_W'(6),
    ALUWB    = STATE_W'(7),
    EXECI    = STATE_W'(8),
    JAL      = STATE_W'(9),
    BEQ      = STATE_W'(10)
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] aluOp;
  logic       pcUpdate, branch, memWriteRaw, regWriteRaw, irWriteRaw;
  logic       supported;
  logic       unusedFunct7;

  assign unusedFunct7 = ^{funct7[6], funct7[4:0]};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    supported = (OP == OPC_LOAD) || (OP == OPC_STORE) || (OP == OPC_RTYPE) ||
                (OP == OPC_ITYPE) || (OP == OPC_JAL) || (OP == OPC_BEQ);
  end

  // Unused encodings fall through to FETCH so a corrupted state self-recovers.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (OP)
          OPC_LOAD, OPC_STORE: state_d = MEMADR;
          OPC_RTYPE:           state_d = EXECR;
          OPC_ITYPE:           state_d = EXECI;
          OPC_JAL:             state_d = JAL;
          OPC_BEQ:             state_d = BEQ;
          default:             state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = OP[5] ? MEMWRITE : MEMREAD;
      MEMREAD: state_d = MEMWB;
      EXECR:   state_d = ALUWB;
      EXECI:   state_d = ALUWB;
      JAL:     state_d = ALUWB;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ResultSrc   = 2'b00;
    AdrSrc      = 1'b0;
    aluOp       = 2'b00;
    pcUpdate    = 1'b0;
    branch      = 1'b0;
    memWriteRaw = 1'b0;
    regWriteRaw = 1'b0;
    irWriteRaw  = 1'b0;
    case (state_q)
      FETCH: begin
        irWriteRaw = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        pcUpdate   = 1'b1;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc   = 2'b01;
        regWriteRaw = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc      = 1'b1;
        memWriteRaw = 1'b1;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        aluOp   = 2'b10;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluOp   = 2'b10;
      end
      ALUWB:    regWriteRaw = 1'b1;
      JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcUpdate = 1'b1;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        aluOp   = 2'b01;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (OP)
      OPC_STORE: ImmSrc = 2'b01;
      OPC_BEQ:   ImmSrc = 2'b10;
      OPC_JAL:   ImmSrc = 2'b11;
      default:   ImmSrc = 2'b00;
    endcase
  end

  // Subtract only for R-type with funct7[5]; addi reuses funct7 bits as immediate.
  always_comb begin
    ALUControl = 3'b000;
    case (aluOp)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      default: begin
        case (funct3)
          3'b000:  ALUControl = (OP[5] & funct7[5]) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
    endcase
  end

  // Write enables are gated by RESET so nothing is written while reset is held.
  assign PCWrite  = RESET & (pcUpdate | (branch & Zero));
  assign MemWrite = RESET & memWriteRaw;
  assign RegWrite = RESET & regWriteRaw;
  assign IRWrite  = RESET & irWriteRaw;
  assign Illegal  = RESET & (state_q == DECODE) & ~supported;
  assign STATE    = state_q;

endmodule
